// File: rtl/sipo_pkg.sv
// sipo_pkg
//   Shared definitions for the serial-to-parallel stream block and its
//   holding register: bit-order enum, counter-width helper and the
//   parity reduction used when the parity option is built in.
package sipo_pkg;

  // Widest word the parity helper reduces; narrower words are zero-extended,
  // which leaves the XOR reduction unchanged.
  localparam int PAR_MAX_W = 1024;

  typedef enum logic {
    LSB_FIRST   = 1'b0,
    MSB_FIRST_E = 1'b1
  } bit_order_e;

  // Bit counter must hold 0..w so the parity build can count the extra bit.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/sipo_hold_reg.sv
// sipo_hold_reg
//   One-entry valid/ready output register. A load sets valid and captures
//   data; a consumer handshake clears valid. Load and accept on the same
//   edge keep valid high with the new data (no bubble).
//   The producer must not load while valid_o && !ready_i.
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   load_i      capture data_i this edge
//   data_i      word to capture
//   ready_i     consumer accepts data_o
//   valid_o     data_o holds a word
//   data_o      held word (stable while valid_o && !ready_i)
module sipo_hold_reg #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/serial_to_parallel_stream.sv
// serial_to_parallel_stream
//   Bit-serial to word-parallel converter with valid/ready on both sides.
//   A new word may assemble in the shift register while the previous one
//   waits in the holding register; only the completing bit stalls.
//   Build option: define SIPO_PARITY_EN to consume one even-parity bit
//   after each word and report parity_err with the held word.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   serial_in/valid/ready      serial input handshake
//   flush                      discard the partially assembled word
//   par_data/valid/ready       parallel output handshake
//   bit_count                  bits currently assembled
//   parity_err                 parity mismatch of held word (0 without option)
module serial_to_parallel_stream
  import sipo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             serial_in,
  input  logic                             serial_valid,
  output logic                             serial_ready,
  input  logic                             flush,
  output logic [DATA_WIDTH-1:0]            par_data,
  output logic                             par_valid,
  input  logic                             par_ready,
  output logic [cnt_width(DATA_WIDTH)-1:0] bit_count,
  output logic                             parity_err
);

  localparam int         CW    = cnt_width(DATA_WIDTH);
  localparam bit_order_e ORDER = bit_order_e'(MSB_FIRST);
`ifdef SIPO_PARITY_EN
  localparam int LAST = DATA_WIDTH;
`else
  localparam int LAST = DATA_WIDTH - 1;
`endif
  localparam logic [CW-1:0] LAST_CNT = CW'(LAST);

  logic [DATA_WIDTH-1:0] shift_q, shift_d, shifted;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  accept, complete;
  logic [DATA_WIDTH:0]   load_word, hold_data;

  // Empty / filling / held / filling+held are implied by cnt_q and par_valid.
  assign serial_ready = !(cnt_q == LAST_CNT && par_valid && !par_ready);
  assign accept       = serial_valid && serial_ready;
  assign complete     = accept && !flush && (cnt_q == LAST_CNT);

  always_comb begin
    if (ORDER == MSB_FIRST_E) shifted = {shift_q[DATA_WIDTH-2:0], serial_in};
    else                      shifted = {serial_in, shift_q[DATA_WIDTH-1:1]};
  end

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (flush) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (accept) begin
      cnt_d = complete ? '0 : cnt_q + 1'b1;
`ifdef SIPO_PARITY_EN
      // The parity bit is checked, never shifted into the data word.
      if (cnt_q != LAST_CNT) shift_d = shifted;
`else
      shift_d = shifted;
`endif
    end
  end

`ifdef SIPO_PARITY_EN
  assign load_word = {even_parity(PAR_MAX_W'(shift_q)) ^ serial_in, shift_q};
`else
  assign load_word = {1'b0, shifted};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  sipo_hold_reg #(.W(DATA_WIDTH + 1)) u_hold (
    .clk     (clk),
    .reset   (reset),
    .load_i  (complete),
    .data_i  (load_word),
    .ready_i (par_ready),
    .valid_o (par_valid),
    .data_o  (hold_data)
  );

  assign par_data   = hold_data[DATA_WIDTH-1:0];
  assign parity_err = hold_data[DATA_WIDTH];
  assign bit_count  = cnt_q;

endmodule

// File: tb/tb_serial_to_parallel_stream.sv
module tb_serial_to_parallel_stream;
  localparam int DW = 8;
  localparam int CW = $clog2(DW + 1);
`ifdef SIPO_PARITY_EN
  localparam int NB = DW + 1;
`else
  localparam int NB = DW;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic serial_in = 1'b0, serial_valid = 1'b0, flush = 1'b0, par_ready = 1'b0;
  logic sr0, sr1, pv0, pv1, pe0, pe1;
  logic [DW-1:0] pd0, pd1;
  logic [CW-1:0] bc0, bc1;

  int checks = 0;
  int errors = 0;

  // Reference model: received bits as a list, one held word per bit order.
  bit            m_bits[$];
  logic [DW-1:0] m_w0 = '0, m_w1 = '0;
  bit            m_valid = 1'b0;
  bit            m_perr = 1'b0;

  serial_to_parallel_stream #(.DATA_WIDTH(DW), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .reset(reset), .serial_in(serial_in), .serial_valid(serial_valid),
    .serial_ready(sr0), .flush(flush), .par_data(pd0), .par_valid(pv0),
    .par_ready(par_ready), .bit_count(bc0), .parity_err(pe0));

  serial_to_parallel_stream #(.DATA_WIDTH(DW), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .reset(reset), .serial_in(serial_in), .serial_valid(serial_valid),
    .serial_ready(sr1), .flush(flush), .par_data(pd1), .par_valid(pv1),
    .par_ready(par_ready), .bit_count(bc1), .parity_err(pe1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return !(m_bits.size() == NB - 1 && m_valid && !par_ready);
  endfunction

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_bits.delete();
      m_valid = 1'b0;
      m_w0 = '0;
      m_w1 = '0;
      m_perr = 1'b0;
    end else begin
      bit rdy, xfer, done, par;
      rdy  = m_ready();
      xfer = m_valid && par_ready;
      done = 1'b0;
      if (flush) m_bits.delete();
      else if (serial_valid && rdy) begin
        m_bits.push_back(serial_in);
        if (m_bits.size() == NB) begin
          for (int i = 0; i < DW; i++) begin
            m_w0[i]        = m_bits[i];
            m_w1[DW-1-i]   = m_bits[i];
          end
          par = 1'b0;
          for (int i = 0; i < NB; i++) par ^= m_bits[i];
          m_perr = (NB > DW) ? par : 1'b0;
          m_bits.delete();
          done = 1'b1;
        end
      end
      if (done) m_valid = 1'b1;
      else if (xfer) m_valid = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      chk("serial_ready0", 32'(sr0), 32'(m_ready()));
      chk("serial_ready1", 32'(sr1), 32'(m_ready()));
      chk("bit_count0", 32'(bc0), 32'(m_bits.size()));
      chk("bit_count1", 32'(bc1), 32'(m_bits.size()));
      chk("par_valid0", 32'(pv0), 32'(m_valid));
      chk("par_valid1", 32'(pv1), 32'(m_valid));
      chk("par_data_lsb", 32'(pd0), 32'(m_w0));
      chk("par_data_msb", 32'(pd1), 32'(m_w1));
      chk("parity_err0", 32'(pe0), 32'(m_perr));
      chk("parity_err1", 32'(pe1), 32'(m_perr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      serial_valid = 1'b1;
      serial_in    = bits[i];
      tick();
    end
    serial_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_par_valid", 32'(pv0), 32'd0);
    chk("rst_bit_count", 32'(bc0), 32'd0);
    chk("rst_par_data", 32'(pd0), 32'd0);
    chk("rst_serial_ready", 32'(sr0), 32'd1);
    tick();

    // 1,0,1,0,0,1,0,1 in arrival order
    par_ready = 1'b1;
    send(16'h00A5, NB);
    chk("a5_valid", 32'(pv0), 32'd1);
    chk("a5_lsb", 32'(pd0), 32'hA5);
    chk("a5_msb", 32'(pd1), 32'hA5);
    chk("a5_model", 32'(m_w0), 32'hA5);
    tick();
    chk("a5_one_cycle", 32'(pv0), 32'd0);

    // 0,1,0,1,1,0,1,0
    send(16'h005A, NB);
    chk("5a_msb", 32'(pd1), 32'h5A);
    chk("5a_model", 32'(m_w1), 32'h5A);
    tick();

`ifndef SIPO_PARITY_EN
    // Backpressure: 0xFF held, next word stalls on its last bit.
    par_ready = 1'b0;
    send(16'h00FF, 15);
    serial_valid = 1'b1;
    serial_in    = 1'b0;
    tick();
    tick();
    chk("bp_ready_low", 32'(sr0), 32'd0);
    chk("bp_count7", 32'(bc0), 32'd7);
    chk("bp_hold_ff", 32'(pd0), 32'hFF);
    par_ready = 1'b1;
    tick();
    par_ready    = 1'b0;
    serial_valid = 1'b0;
    chk("bp_next_00", 32'(pd0), 32'h00);
    chk("bp_no_bubble", 32'(pv0), 32'd1);
    chk("bp_count0", 32'(bc0), 32'd0);
    par_ready = 1'b1;
    tick();

    // Flush with a simultaneous bit.
    send(16'h0005, 3);
    flush        = 1'b1;
    serial_valid = 1'b1;
    serial_in    = 1'b1;
    tick();
    flush        = 1'b0;
    serial_valid = 1'b0;
    chk("flush_count0", 32'(bc0), 32'd0);
    send(16'h003C, 8);
    chk("flush_3c_lsb", 32'(pd0), 32'h3C);
    chk("flush_3c_msb", 32'(pd1), 32'h3C);
    chk("flush_valid", 32'(pv0), 32'd1);
    tick();
`else
    send(16'h0107, NB);
    chk("par_ok_data", 32'(pd0), 32'h07);
    chk("par_ok_err", 32'(pe0), 32'd0);
    tick();
    send(16'h0007, NB);
    chk("par_bad_valid", 32'(pv0), 32'd1);
    chk("par_bad_err", 32'(pe0), 32'd1);
    tick();
`endif

    // Asynchronous reset with a held word and a partial word.
    par_ready = 1'b0;
    send(16'h0181, NB);
    send(16'h0015, 5);
    chk("pre_rst_count5", 32'(bc0), 32'd5);
    chk("pre_rst_valid", 32'(pv0), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(pv0), 32'd0);
    chk("arst_count", 32'(bc0), 32'd0);
    chk("arst_data", 32'(pd0), 32'd0);
    chk("arst_data_msb", 32'(pd1), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 32'(sr0), 32'd1);
    tick();

    for (int n = 0; n < 3000; n++) begin
      serial_valid = ($urandom_range(0, 9) < 7);
      serial_in    = 1'($urandom);
      par_ready    = 1'($urandom_range(0, 1));
      flush        = ($urandom_range(0, 31) == 0);
      tick();
    end
    serial_valid = 1'b0;
    flush        = 1'b0;
    par_ready    = 1'b1;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
